// File: rtl/fb_scroll_if.sv
// Bus bundle between the scroll controller, the video timing block,
// the freq BRAM read port and the frame buffer RAM.
interface fb_scroll_if #(
    parameter int unsigned ADDR_W = 17
) ();
    logic [8:0]        x;
    logic [7:0]        y;
    logic              lower_blank;
    logic              scroll_en;
    logic              line_valid;
    logic              line_taken;
    logic              line_ren;
    logic [8:0]        line_raddr;
    logic [7:0]        line_rdata;
    logic [ADDR_W-1:0] fb_addr;
    logic [7:0]        fb_wdata;
    logic              fb_we;
    logic              fb_ready;
    logic [7:0]        y_offset;

    modport master (
        input  x, y, lower_blank, scroll_en, line_valid, line_rdata,
        output line_taken, line_ren, line_raddr, fb_addr, fb_wdata, fb_we,
               fb_ready, y_offset
    );

    modport slave (
        output x, y, lower_blank, scroll_en, line_valid, line_rdata,
        input  line_taken, line_ren, line_raddr, fb_addr, fb_wdata, fb_we,
               fb_ready, y_offset
    );
endinterface

// File: rtl/fb_scroll_ctrl.sv
// Frame buffer owner: power-on clear, scrolled video read addressing and
// spectrum line copies during lower blanking. FB_CLEAR_EN enables the clear.
module fb_scroll_ctrl #(
    parameter int unsigned WIDTH      = 320,
    parameter int unsigned HEIGHT     = 240,
    parameter int unsigned SCROLL_DIV = 4,
    parameter int unsigned ADDR_W     = 17
) (
    input  logic        clk,
    input  logic        resetn,
    fb_scroll_if.master bus
);

    localparam int unsigned FC_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam int unsigned PIX  = WIDTH * HEIGHT;

    localparam logic [1:0] S_CLEAR = 2'd0;
    localparam logic [1:0] S_VIDEO = 2'd1;
    localparam logic [1:0] S_COPY  = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

`ifdef FB_CLEAR_EN
    localparam logic [1:0] S_RESET = S_CLEAR;
`else
    localparam logic [1:0] S_RESET = S_VIDEO;
`endif

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [FC_W-1:0]   r_frame_cnt;
    logic              r_due;
    logic              r_lb_d;
    logic [7:0]        r_y_offset;
    logic              r_line_taken;
    logic              r_line_ren;
    logic [8:0]        r_line_raddr;
    logic [ADDR_W-1:0] r_fb_addr;
    logic [7:0]        r_fb_wdata;
    logic              r_fb_we;
    logic              r_fb_ready;

    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic [FC_W-1:0]   w_frame_nxt;
    logic              w_due_nxt;
    logic [7:0]        w_y_offset_nxt;
    logic              w_line_taken_nxt;
    logic              w_line_ren_nxt;
    logic [8:0]        w_line_raddr_nxt;
    logic [ADDR_W-1:0] w_fb_addr_nxt;
    logic [7:0]        w_fb_wdata_nxt;
    logic              w_fb_we_nxt;
    logic              w_fb_ready_nxt;

    logic              w_lb_rise;
    logic [8:0]        w_y_sum;
    logic [8:0]        w_y_mod;
    logic [ADDR_W-1:0] w_vid_addr;
    logic [ADDR_W-1:0] w_copy_base;

    // Scrolled video address; porch coordinates are addressed but never written
    assign w_lb_rise   = bus.lower_blank & ~r_lb_d;
    assign w_y_sum     = {1'b0, bus.y} + {1'b0, r_y_offset};
    assign w_y_mod     = (w_y_sum >= 9'(HEIGHT)) ? (w_y_sum - 9'(HEIGHT)) : w_y_sum;
    assign w_vid_addr  = ADDR_W'(bus.x) + ADDR_W'(w_y_mod) * ADDR_W'(WIDTH);
    assign w_copy_base = ADDR_W'(r_y_offset) * ADDR_W'(WIDTH);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_RESET;
            r_cnt        <= '0;
            r_frame_cnt  <= '0;
            r_due        <= 1'b0;
            r_lb_d       <= 1'b0;
            r_y_offset   <= '0;
            r_line_taken <= 1'b0;
            r_line_ren   <= 1'b0;
            r_line_raddr <= '0;
            r_fb_addr    <= '0;
            r_fb_wdata   <= '0;
            r_fb_we      <= 1'b0;
            r_fb_ready   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_frame_cnt  <= w_frame_nxt;
            r_due        <= w_due_nxt;
            r_lb_d       <= bus.lower_blank;
            r_y_offset   <= w_y_offset_nxt;
            r_line_taken <= w_line_taken_nxt;
            r_line_ren   <= w_line_ren_nxt;
            r_line_raddr <= w_line_raddr_nxt;
            r_fb_addr    <= w_fb_addr_nxt;
            r_fb_wdata   <= w_fb_wdata_nxt;
            r_fb_we      <= w_fb_we_nxt;
            r_fb_ready   <= w_fb_ready_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_frame_nxt      = r_frame_cnt;
        w_due_nxt        = r_due;
        w_y_offset_nxt   = r_y_offset;
        w_line_taken_nxt = 1'b0;
        w_line_ren_nxt   = 1'b0;
        w_line_raddr_nxt = '0;
        w_fb_addr_nxt    = w_vid_addr;
        w_fb_wdata_nxt   = '0;
        w_fb_we_nxt      = 1'b0;
        w_fb_ready_nxt   = r_fb_ready;

        case (r_state)
            S_CLEAR: begin
                if (r_cnt == ADDR_W'(PIX)) begin
                    w_fb_ready_nxt = 1'b1;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = S_VIDEO;
                end else begin
                    w_fb_we_nxt   = 1'b1;
                    w_fb_addr_nxt = r_cnt;
                    w_cnt_nxt     = r_cnt + ADDR_W'(1);
                end
            end

            S_VIDEO: begin
                w_fb_ready_nxt = 1'b1;
                // Frame counter freezes while a scroll step is pending
                if (w_lb_rise && !r_due) begin
                    if (r_frame_cnt == FC_W'(SCROLL_DIV - 1)) begin
                        w_frame_nxt = '0;
                        w_due_nxt   = 1'b1;
                    end else begin
                        w_frame_nxt = r_frame_cnt + FC_W'(1);
                    end
                end
                if (bus.lower_blank) begin
                    if (w_due_nxt && bus.line_valid && bus.scroll_en) begin
                        w_state_nxt      = S_COPY;
                        w_cnt_nxt        = '0;
                        w_line_ren_nxt   = 1'b1;
                        w_line_raddr_nxt = '0;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end

            S_COPY: begin
                w_fb_ready_nxt = 1'b1;
                if (r_cnt < ADDR_W'(WIDTH - 1)) begin
                    w_line_ren_nxt   = 1'b1;
                    w_line_raddr_nxt = 9'(r_cnt + ADDR_W'(1));
                end
                // Read data trails the issued address by one cycle
                if (r_cnt != '0) begin
                    w_fb_we_nxt    = 1'b1;
                    w_fb_addr_nxt  = w_copy_base + r_cnt - ADDR_W'(1);
                    w_fb_wdata_nxt = bus.line_rdata;
                end
                if (r_cnt == ADDR_W'(WIDTH)) begin
                    w_line_taken_nxt = 1'b1;
                    w_due_nxt        = 1'b0;
                    w_y_offset_nxt   = (r_y_offset == 8'(HEIGHT - 1)) ? 8'd0
                                                                      : r_y_offset + 8'd1;
                    w_cnt_nxt        = '0;
                    w_state_nxt      = S_WAIT;
                end else begin
                    w_cnt_nxt = r_cnt + ADDR_W'(1);
                end
            end

            S_WAIT: begin
                w_fb_ready_nxt = 1'b1;
                if (!bus.lower_blank) begin
                    w_state_nxt = S_VIDEO;
                end
            end

            default: begin
                w_state_nxt = S_RESET;
            end
        endcase
    end

    assign bus.line_taken = r_line_taken;
    assign bus.line_ren   = r_line_ren;
    assign bus.line_raddr = r_line_raddr;
    assign bus.fb_addr    = r_fb_addr;
    assign bus.fb_wdata   = r_fb_wdata;
    assign bus.fb_we      = r_fb_we;
    assign bus.fb_ready   = r_fb_ready;
    assign bus.y_offset   = r_y_offset;

endmodule

// File: tb/tb_fb_scroll_ctrl.sv
// Bench for fb_scroll_ctrl: address vector table, frame-level reference model
// for scrolling/copies, a small-width instance for y_offset wrap, async reset.
module tb_fb_scroll_ctrl;

    localparam int unsigned W     = 320;
    localparam int unsigned H     = 240;
    localparam int unsigned DIV   = 4;
    localparam int unsigned AW    = 17;
    localparam int unsigned W2    = 8;
    localparam int unsigned BLANK = 330;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    fb_scroll_if #(.ADDR_W(AW)) bus ();
    fb_scroll_if #(.ADDR_W(AW)) bus2 ();

    fb_scroll_ctrl #(.WIDTH(W), .HEIGHT(H), .SCROLL_DIV(DIV), .ADDR_W(AW)) dut (
        .clk(clk), .resetn(resetn), .bus(bus));
    fb_scroll_ctrl #(.WIDTH(W2), .HEIGHT(H), .SCROLL_DIV(1), .ADDR_W(AW)) dut2 (
        .clk(clk), .resetn(resetn), .bus(bus2));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Freq BRAM models, one cycle read latency
    logic [7:0] line_mem [W];
    always @(posedge clk) if (bus.line_ren) bus.line_rdata <= line_mem[bus.line_raddr];
    always @(posedge clk) if (bus2.line_ren) bus2.line_rdata <= bus2.line_raddr[7:0];

    typedef struct packed { logic [AW-1:0] a; logic [7:0] d; } wr_t;
    wr_t wq[$];
    wr_t wq2[$];
    int  taken_cnt = 0;
    int  taken2 = 0;

    always @(negedge clk) begin
        if (bus.fb_we) wq.push_back({bus.fb_addr, bus.fb_wdata});
        if (bus.line_taken) taken_cnt++;
        if (bus2.fb_we) wq2.push_back({bus2.fb_addr, bus2.fb_wdata});
        if (bus2.line_taken) taken2++;
    end

    // Reference model: frames seen, pending scroll, top row
    int m_frames = 0;
    bit m_due = 0;
    int m_yoff = 0;

    function automatic int vaddr(input int x, input int y, input int yo, input int w);
        int s;
        s = y + yo;
        if (s >= int'(H)) s -= int'(H);
        return x + s * w;
    endfunction

    task automatic frame(input logic lv, input logic se);
        int bad;
        @(negedge clk);
        bus.line_valid = lv; bus.scroll_en = se; bus.lower_blank = 1'b0;
        repeat (3) @(negedge clk);
        bus.lower_blank = 1'b1;
        repeat (BLANK) @(negedge clk);
        bus.lower_blank = 1'b0;
        repeat (2) @(negedge clk);
        if (!m_due) begin
            m_frames++;
            if (m_frames % DIV == 0) m_due = 1;
        end
        if (m_due && lv && se) begin
            bad = 0;
            foreach (wq[i])
                if (wq[i].a !== AW'(m_yoff * W + i) || wq[i].d !== line_mem[i]) bad++;
            chk("copy_write_count", wq.size(), W);
            chk("copy_write_errors", bad, 0);
            chk("copy_line_taken", taken_cnt, 1);
            m_due = 0;
            m_yoff = (m_yoff + 1) % H;
        end else begin
            chk("idle_write_count", wq.size(), 0);
            chk("idle_line_taken", taken_cnt, 0);
        end
        chk("y_offset", bus.y_offset, m_yoff);
        wq.delete();
        taken_cnt = 0;
    endtask

    task automatic addr_check(input logic [8:0] x, input logic [7:0] y, input int exp);
        @(negedge clk);
        bus.x = x; bus.y = y;
        @(negedge clk);
        chk("video_addr", bus.fb_addr, exp);
        chk("video_no_we", bus.fb_we, 0);
    endtask

    typedef struct {
        logic [8:0]    x;
        logic [7:0]    y;
        logic [AW-1:0] exp;
    } vec_t;
    vec_t tbl[7];

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int found;
        int nclr, clr_bad;

        tbl[0] = '{9'd5,   8'd1,   17'd325};
        tbl[1] = '{9'd319, 8'd239, 17'd76799};
        tbl[2] = '{9'd0,   8'd0,   17'd0};
        tbl[3] = '{9'd100, 8'd10,  17'd3300};
        tbl[4] = '{9'd319, 8'd0,   17'd319};
        tbl[5] = '{9'd0,   8'd239, 17'd76480};
        tbl[6] = '{9'd400, 8'd250, 17'd3600};

        bus.x = '0; bus.y = '0; bus.lower_blank = 0; bus.scroll_en = 0; bus.line_valid = 0;
        bus2.x = '0; bus2.y = '0; bus2.lower_blank = 0; bus2.scroll_en = 1; bus2.line_valid = 1;
        foreach (line_mem[k]) line_mem[k] = 8'(k);

        repeat (2) @(negedge clk);
        chk("rst_fb_we", bus.fb_we, 0);
        chk("rst_fb_addr", bus.fb_addr, 0);
        chk("rst_fb_ready", bus.fb_ready, 0);
        chk("rst_line_ren", bus.line_ren, 0);
        chk("rst_y_offset", bus.y_offset, 0);
        chk("rst_line_taken", bus.line_taken, 0);

        resetn = 1'b1;
`ifdef FB_CLEAR_EN
        nclr = 0; clr_bad = 0;
        for (int i = 0; i < int'(W * H) + 20; i++) begin
            @(negedge clk);
            if (bus.fb_ready) break;
            if (bus.fb_we) begin
                if (bus.fb_addr !== AW'(nclr) || bus.fb_wdata !== 8'd0) clr_bad++;
                nclr++;
            end
        end
        chk("clear_write_count", nclr, W * H);
        chk("clear_write_errors", clr_bad, 0);
        chk("clear_ready", bus.fb_ready, 1);
        @(negedge clk);
        chk("clear_we_off", bus.fb_we, 0);
`else
        nclr = 0; clr_bad = 0;
        @(negedge clk);
        chk("ready_first_clock", bus.fb_ready, 1);
        chk("no_clear_we", bus.fb_we, 0);
`endif
        wq.delete(); wq2.delete();

        foreach (tbl[i]) addr_check(tbl[i].x, tbl[i].y, int'(tbl[i].exp));

        // Ramp line, copy on the 4th blank, then hold on line_valid / scroll_en
        for (int f = 0; f < 4; f++) frame(1, 1);
        for (int f = 0; f < 3; f++) frame(1, 1);
        frame(0, 1);
        frame(1, 1);
        for (int f = 0; f < 3; f++) frame(1, 1);
        frame(1, 0);
        frame(0, 0);
        frame(1, 1);
        addr_check(9'd5, 8'd1, vaddr(5, 1, m_yoff, W));

        // Randomized frames and addresses
        for (int f = 0; f < 16; f++) begin
            foreach (line_mem[k]) line_mem[k] = 8'($urandom);
            frame(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 3) != 0));
            begin
                int rx, ry;
                rx = (f % 5 == 4) ? $urandom_range(320, 511) : $urandom_range(0, 319);
                ry = (f % 7 == 6) ? $urandom_range(240, 255) : $urandom_range(0, 239);
                addr_check(9'(rx), 8'(ry), vaddr(rx, ry, m_yoff, W));
            end
        end

        // Narrow instance: walk y_offset up to 239 and wrap it
        for (int f = 0; f < int'(H); f++) begin
            if (f == 1) chk("w2_y_offset_step", bus2.y_offset, 1);
            if (f == int'(H) - 1) begin
                chk("w2_y_offset_top", bus2.y_offset, H - 1);
                @(negedge clk);
                bus2.x = 9'd5; bus2.y = 8'd1;
                @(negedge clk);
                chk("w2_addr_wrapped_row", bus2.fb_addr, 5);
                wq2.delete();
                taken2 = 0;
            end
            bus2.lower_blank = 1'b1;
            repeat (14) @(negedge clk);
            bus2.lower_blank = 1'b0;
            repeat (3) @(negedge clk);
        end
        chk("w2_wrap_write_count", wq2.size(), W2);
        clr_bad = 0;
        foreach (wq2[i])
            if (wq2[i].a !== AW'((H - 1) * W2 + i) || wq2[i].d !== 8'(i)) clr_bad++;
        chk("w2_wrap_write_errors", clr_bad, 0);
        chk("w2_wrap_taken", taken2, 1);
        chk("w2_y_offset_wrapped", bus2.y_offset, 0);

        // Async reset in the middle of a copy
        for (int i = 0; i < int'(DIV) + 1 && !m_due; i++) frame(0, 1);
        @(negedge clk);
        bus.line_valid = 1; bus.scroll_en = 1; bus.lower_blank = 0;
        repeat (3) @(negedge clk);
        bus.lower_blank = 1'b1;
        found = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.line_ren && bus.line_raddr == 9'd100) begin
                found = 1;
                break;
            end
        end
        chk("midcopy_reached_k100", found, 1);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_fb_we", bus.fb_we, 0);
        chk("async_rst_fb_addr", bus.fb_addr, 0);
        chk("async_rst_line_ren", bus.line_ren, 0);
        chk("async_rst_line_raddr", bus.line_raddr, 0);
        chk("async_rst_fb_wdata", bus.fb_wdata, 0);
        chk("async_rst_fb_ready", bus.fb_ready, 0);
        chk("async_rst_y_offset", bus.y_offset, 0);
        @(negedge clk);
        bus.lower_blank = 1'b0;
        resetn = 1'b1;
        @(negedge clk);
`ifdef FB_CLEAR_EN
        chk("restart_clear_we", bus.fb_we, 1);
        chk("restart_clear_addr", bus.fb_addr, 0);
`else
        chk("restart_ready", bus.fb_ready, 1);
        chk("restart_no_we", bus.fb_we, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
